// File: rtl/ones_counter_bist_ctrl_if.sv
// Bus interface for the ones-counter BIST sequencer.
// master = the sequencer (drives the vector and results, reads start and both counter outputs).
// slave  = the environment (drives start and the counters, reads the vector and results).
interface ones_counter_bist_ctrl_if;
    logic       start;
    logic       a;
    logic       b;
    logic       c;
    logic       y1;
    logic       y0;
    logic       y11;
    logic       y00;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic       fail_valid;
    logic [2:0] first_fail_vec;

    modport master (
        input  start, y1, y0, y11, y00,
        output a, b, c, busy, done, pass, err_count, fail_valid, first_fail_vec
    );

    modport slave (
        output start, y1, y0, y11, y00,
        input  a, b, c, busy, done, pass, err_count, fail_valid, first_fail_vec
    );
endinterface

// File: rtl/ones_counter_bist_ctrl.sv
// Clocked self-checking sequencer for the 3-input ones counter.
// Walks {a,b,c} through 000..111, holds each vector SETTLE_CYCLES+2 cycles,
// compares the two counter implementations once per vector and reports
// pass/fail, the mismatch count and the first failing vector.
// SETTLE_CYCLES must be in 1..15.
// Optional macro ONES_BIST_GOLDEN_EN: also compare both implementations
// against a built-in a+b+c golden result.
module ones_counter_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input logic                       clk,
    input logic                       rst,
    ones_counter_bist_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] abc_q, abc_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] err_count_q, err_count_d;
    logic       fail_valid_q, fail_valid_d;
    logic [2:0] first_fail_vec_q, first_fail_vec_d;
    logic       mismatch;

    // Result comparison; X/Z on any counter output is treated as a mismatch
    always_comb begin
        logic [1:0] res_a;
        logic [1:0] res_b;
`ifdef ONES_BIST_GOLDEN_EN
        logic [1:0] golden;
`endif
        res_a    = {bus.y1, bus.y0};
        res_b    = {bus.y11, bus.y00};
`ifdef ONES_BIST_GOLDEN_EN
        golden   = 2'({1'b0, vec_q[2]} + {1'b0, vec_q[1]} + {1'b0, vec_q[0]});
        mismatch = (res_a !== golden) || (res_b !== golden);
`else
        mismatch = (res_a !== res_b);
`endif
    end

    // Sequencer next-state and result bookkeeping
    always_comb begin
        state_d          = state_q;
        vec_d            = vec_q;
        cnt_d            = cnt_q;
        abc_d            = abc_q;
        pass_d           = pass_q;
        err_count_d      = err_count_q;
        fail_valid_d     = fail_valid_q;
        first_fail_vec_d = first_fail_vec_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d          = S_APPLY;
                    vec_d            = 3'd0;
                    pass_d           = 1'b0;
                    err_count_d      = 4'd0;
                    fail_valid_d     = 1'b0;
                    first_fail_vec_d = 3'd0;
                end
            end
            S_APPLY: begin
                abc_d   = vec_q;
                cnt_d   = SETTLE_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_count_d = err_count_q + 4'd1;
                    if (!fail_valid_q) begin
                        fail_valid_d     = 1'b1;
                        first_fail_vec_d = vec_q;
                    end
                end
                if (vec_q == 3'd7) begin
                    state_d = S_DONE;
                    pass_d  = (err_count_d == 4'd0);
                end else begin
                    vec_d   = vec_q + 3'd1;
                    state_d = S_APPLY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_APPLY) || (state_d == S_WAIT) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            vec_q            <= 3'd0;
            cnt_q            <= 4'd0;
            abc_q            <= 3'd0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= 4'd0;
            fail_valid_q     <= 1'b0;
            first_fail_vec_q <= 3'd0;
        end else begin
            state_q          <= state_d;
            vec_q            <= vec_d;
            cnt_q            <= cnt_d;
            abc_q            <= abc_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            err_count_q      <= err_count_d;
            fail_valid_q     <= fail_valid_d;
            first_fail_vec_q <= first_fail_vec_d;
        end
    end

    assign bus.a              = abc_q[2];
    assign bus.b              = abc_q[1];
    assign bus.c              = abc_q[0];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_count_q;
    assign bus.fail_valid     = fail_valid_q;
    assign bus.first_fail_vec = first_fail_vec_q;

endmodule
